// File: rtl/parallel_frame_tx_if.sv
// Link bundle between the parallel frame transmitter and its FIFO / link consumer.
// master = transmitter side, slave = FIFO + link sink side.
interface parallel_frame_tx_if #(
    parameter int unsigned FIFO_WIDTH = 36
);
    logic                  start;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  fd0;
    logic                  fd1;
    logic                  fd2;
    logic                  fd3;
    logic                  fd4;
    logic                  fd5;
    logic                  fd6;
    logic                  fd7;
    logic                  busy;
    logic                  done;
    logic                  underflow;

    modport master (
        input  start, fifo_empty, fifo_dout,
        output fifo_rd_en, fd0, fd1, fd2, fd3, fd4, fd5, fd6, fd7,
        output busy, done, underflow
    );

    modport slave (
        output start, fifo_empty, fifo_dout,
        input  fifo_rd_en, fd0, fd1, fd2, fd3, fd4, fd5, fd6, fd7,
        input  busy, done, underflow
    );
endinterface

// File: rtl/parallel_frame_tx.sv
// Transmit side of the 8-line parallel frame link: pops 32-bit words from a FWFT FIFO
// and sends NFRAMES frames of {HEADER, 4*FRAME_WORDS payload bytes} per start request.
module parallel_frame_tx #(
    parameter int unsigned FIFO_WIDTH  = 36,
    parameter int unsigned FRAME_WORDS = 12,
    parameter int unsigned NFRAMES     = 100,
    parameter logic [7:0]  HEADER      = 8'hBC,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00,
    parameter logic [7:0]  PAD_BYTE    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    parallel_frame_tx_if.master   link
);
    localparam int unsigned FRAME_BYTES = 4 * FRAME_WORDS;
    localparam int unsigned BCNT_W      = $clog2(FRAME_BYTES);
    localparam int unsigned FCNT_W      = 16;
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(FRAME_BYTES - 1);
    localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(NFRAMES - 1);

    // State names the byte loaded into fd at the next rising edge.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [BCNT_W-1:0] byte_cnt_q,  byte_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]        fd_q,        fd_d;
    logic [23:0]       shift_q,     shift_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              underflow_q, underflow_d;
    logic              rd_en_c;

    logic [FIFO_WIDTH-1:0] head_word;
    logic                  unused_head_hi;
    logic                  word_slot;

    assign head_word      = link.fifo_dout;
    assign unused_head_hi = ^head_word[FIFO_WIDTH-1:32];
    assign word_slot      = (byte_cnt_q[1:0] == 2'd0);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            frame_cnt_q <= '0;
            fd_q        <= IDLE_BYTE;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            fd_q        <= fd_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state, next-byte and pop strobe.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = frame_cnt_q;
        fd_d        = IDLE_BYTE;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underflow_d = underflow_q;
        rd_en_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fd_d   = IDLE_BYTE;
                busy_d = 1'b0;
                if (link.start) begin
                    state_d     = ST_HEADER;
                    frame_cnt_d = '0;
                    underflow_d = 1'b0;
                end
            end

            ST_HEADER: begin
                fd_d       = HEADER;
                byte_cnt_d = '0;
                busy_d     = 1'b1;
                state_d    = ST_PAYLOAD;
            end

            ST_PAYLOAD: begin
                busy_d = 1'b1;
                if (word_slot) begin
                    if (!link.fifo_empty) begin
                        rd_en_c = 1'b1;
                        fd_d    = head_word[31:24];
                        shift_d = head_word[23:0];
                    end else begin
                        // Keep frame length fixed: pad the whole word slot.
                        fd_d        = PAD_BYTE;
                        shift_d     = {PAD_BYTE, PAD_BYTE, PAD_BYTE};
                        underflow_d = 1'b1;
                    end
                end else begin
                    fd_d    = shift_q[23:16];
                    shift_d = {shift_q[15:0], 8'h00};
                end

                if (byte_cnt_q == LAST_BYTE) begin
                    byte_cnt_d = '0;
                    if (frame_cnt_q == LAST_FRAME) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        state_d     = ST_HEADER;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign link.fifo_rd_en = rd_en_c;
    assign link.fd0        = fd_q[7];
    assign link.fd1        = fd_q[6];
    assign link.fd2        = fd_q[5];
    assign link.fd3        = fd_q[4];
    assign link.fd4        = fd_q[3];
    assign link.fd5        = fd_q[2];
    assign link.fd6        = fd_q[1];
    assign link.fd7        = fd_q[0];
    assign link.busy       = busy_q;
    assign link.done       = done_q;
    assign link.underflow  = underflow_q;
endmodule

// File: tb/tb_parallel_frame_tx.sv
// Bench for parallel_frame_tx: a 2-word/1-frame instance for the short trace and a
// 12-word/3-frame instance checked against a frame-stream model built from the FIFO contents.
module tb_parallel_frame_tx;
    localparam int FW = 12;
    localparam int NF = 3;
    localparam int BURST = NF * (1 + 4 * FW);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    parallel_frame_tx_if #(.FIFO_WIDTH(36)) aif ();
    parallel_frame_tx_if #(.FIFO_WIDTH(36)) bif ();

    parallel_frame_tx #(.FIFO_WIDTH(36), .FRAME_WORDS(2), .NFRAMES(1)) dut_a (
        .clk(clk), .rst(rst), .link(aif)
    );
    parallel_frame_tx #(.FIFO_WIDTH(36), .FRAME_WORDS(FW), .NFRAMES(NF)) dut_b (
        .clk(clk), .rst(rst), .link(bif)
    );

    // FWFT FIFO models
    logic [35:0] mem_a [0:15];
    int rd_ptr_a = 0, wr_ptr_a = 0, pops_a = 0;
    assign aif.fifo_empty = (rd_ptr_a == wr_ptr_a);
    assign aif.fifo_dout  = mem_a[rd_ptr_a[3:0]];
    always @(posedge clk) if (aif.fifo_rd_en) begin
        rd_ptr_a <= rd_ptr_a + 1;
        pops_a   <= pops_a + 1;
    end

    logic [35:0] mem_b [0:1023];
    int rd_ptr_b = 0, wr_ptr_b = 0, pops_b = 0;
    assign bif.fifo_empty = (rd_ptr_b == wr_ptr_b);
    assign bif.fifo_dout  = mem_b[rd_ptr_b[9:0]];
    always @(posedge clk) if (bif.fifo_rd_en) begin
        rd_ptr_b <= rd_ptr_b + 1;
        pops_b   <= pops_b + 1;
    end

    logic [7:0] fd_a, fd_b;
    assign fd_a = {aif.fd0, aif.fd1, aif.fd2, aif.fd3, aif.fd4, aif.fd5, aif.fd6, aif.fd7};
    assign fd_b = {bif.fd0, bif.fd1, bif.fd2, bif.fd3, bif.fd4, bif.fd5, bif.fd6, bif.fd7};

    logic [35:0] model_words [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  obs_fd [$];
    logic        obs_busy [$];
    logic        obs_done [$];
    logic        obs_uf [$];

    task automatic push_b(input logic [35:0] w);
        mem_b[wr_ptr_b[9:0]] = w;
        wr_ptr_b = wr_ptr_b + 1;
        model_words.push_back(w);
    endtask

    task automatic clear_b();
        wr_ptr_b = rd_ptr_b;
        model_words.delete();
        exp_q.delete();
        obs_fd.delete();
        obs_busy.delete();
        obs_done.delete();
        obs_uf.delete();
    endtask

    // Expected link bytes for one burst when 'avail' FIFO words exist at start.
    task automatic build_exp(input int avail);
        int idx = 0;
        logic [35:0] w;
        exp_q.delete();
        for (int f = 0; f < NF; f++) begin
            exp_q.push_back(8'hBC);
            for (int k = 0; k < FW; k++) begin
                if (idx < avail) begin
                    w = model_words[idx];
                    idx++;
                    exp_q.push_back(w[31:24]);
                    exp_q.push_back(w[23:16]);
                    exp_q.push_back(w[15:8]);
                    exp_q.push_back(w[7:0]);
                end else begin
                    repeat (4) exp_q.push_back(8'hFF);
                end
            end
        end
    endtask

    task automatic pulse_start_b();
        @(negedge clk) bif.start = 1'b1;
        @(negedge clk) bif.start = 1'b0;
    endtask

    task automatic capture_b(input int n);
        repeat (n) begin
            @(negedge clk);
            obs_fd.push_back(fd_b);
            obs_busy.push_back(bif.busy);
            obs_done.push_back(bif.done);
            obs_uf.push_back(bif.underflow);
        end
    endtask

    task automatic wait_idle_b(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!bif.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aif.start = 1'b0;
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (fd_b !== 8'h00) $display("FAIL reset_fd got %02h exp 00", fd_b); else passed++;
        total++; if ({bif.busy, bif.done, bif.underflow, bif.fifo_rd_en} !== 4'b0)
            $display("FAIL reset_flags got %b exp 0000", {bif.busy, bif.done, bif.underflow, bif.fifo_rd_en});
        else passed++;
        total++; if ({fd_a, aif.busy, aif.done} !== 10'h0)
            $display("FAIL reset_a got %h exp 000", {fd_a, aif.busy, aif.done});
        else passed++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_short_frame();
        logic [7:0] exp1 [0:9];
        int p0;
        exp1 = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hBC, 8'h0F, 8'h00, 8'h00};
        mem_a[wr_ptr_a[3:0]] = {4'h5, 32'h11223344}; wr_ptr_a = wr_ptr_a + 1;
        mem_a[wr_ptr_a[3:0]] = {4'hA, 32'hA5BC0F00}; wr_ptr_a = wr_ptr_a + 1;
        p0 = pops_a;
        @(negedge clk) aif.start = 1'b1;
        @(negedge clk) aif.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (fd_a !== exp1[i]) $display("FAIL t1_byte[%0d] got %02h exp %02h", i, fd_a, exp1[i]); else passed++;
            total++; if (aif.done !== (i == 8)) $display("FAIL t1_done[%0d] got %b exp %b", i, aif.done, (i == 8)); else passed++;
            total++; if (aif.busy !== (i < 9)) $display("FAIL t1_busy[%0d] got %b exp %b", i, aif.busy, (i < 9)); else passed++;
        end
        total++; if (pops_a - p0 !== 2) $display("FAIL t1_pops got %0d exp 2", pops_a - p0); else passed++;
        total++; if (aif.underflow !== 1'b0) $display("FAIL t1_underflow got %b exp 0", aif.underflow); else passed++;
    endtask

    task automatic test_full_burst();
        int p0, nbusy, ndone;
        clear_b();
        for (int i = 0; i < NF * FW; i++) push_b({4'($urandom), 32'(i + 1)});
        build_exp(NF * FW);
        p0 = pops_b;
        pulse_start_b();
        capture_b(BURST + 1);
        nbusy = 0; ndone = 0;
        for (int i = 0; i < BURST; i++) begin
            total++; if (obs_fd[i] !== exp_q[i]) $display("FAIL t2_byte[%0d] got %02h exp %02h", i, obs_fd[i], exp_q[i]); else passed++;
            nbusy += int'(obs_busy[i]);
            ndone += int'(obs_done[i]);
        end
        total++; if (nbusy !== BURST) $display("FAIL t2_busy_cycles got %0d exp %0d", nbusy, BURST); else passed++;
        total++; if (ndone !== 1 || obs_done[BURST-1] !== 1'b1) $display("FAIL t2_done got count %0d last %b exp 1 1", ndone, obs_done[BURST-1]); else passed++;
        total++; if ({obs_fd[BURST], obs_busy[BURST]} !== 9'h000) $display("FAIL t2_idle got %h exp 000", {obs_fd[BURST], obs_busy[BURST]}); else passed++;
        total++; if (pops_b - p0 !== NF * FW) $display("FAIL t2_pops got %0d exp %0d", pops_b - p0, NF * FW); else passed++;
        total++; if (bif.fifo_empty !== 1'b1) $display("FAIL t2_fifo_empty got %b exp 1", bif.fifo_empty); else passed++;
        total++; if (obs_uf[BURST] !== 1'b0) $display("FAIL t2_underflow got %b exp 0", obs_uf[BURST]); else passed++;
    endtask

    task automatic test_underflow();
        int p0;
        clear_b();
        for (int i = 0; i < 5; i++) push_b({4'($urandom), 32'($urandom)});
        build_exp(5);
        p0 = pops_b;
        pulse_start_b();
        capture_b(BURST + 1);
        for (int i = 0; i < BURST; i++) begin
            total++; if (obs_fd[i] !== exp_q[i]) $display("FAIL t3_byte[%0d] got %02h exp %02h", i, obs_fd[i], exp_q[i]); else passed++;
        end
        total++; if (obs_done[BURST-1] !== 1'b1) $display("FAIL t3_done got %b exp 1", obs_done[BURST-1]); else passed++;
        total++; if (obs_uf[0] !== 1'b0) $display("FAIL t3_underflow_start got %b exp 0", obs_uf[0]); else passed++;
        total++; if (obs_uf[BURST] !== 1'b1) $display("FAIL t3_underflow_sticky got %b exp 1", obs_uf[BURST]); else passed++;
        total++; if (pops_b - p0 !== 5) $display("FAIL t3_pops got %0d exp 5", pops_b - p0); else passed++;
    endtask

    task automatic test_restart_held();
        bit ok;
        clear_b();
        for (int i = 0; i < 30; i++) push_b({4'($urandom), 32'($urandom)});
        build_exp(30);
        pulse_start_b();
        capture_b(60);
        bif.start = 1'b1;
        capture_b(BURST - 60 + 2);
        for (int i = 0; i < BURST; i++) begin
            total++; if (obs_fd[i] !== exp_q[i]) $display("FAIL t4_byte[%0d] got %02h exp %02h", i, obs_fd[i], exp_q[i]); else passed++;
        end
        total++; if (obs_uf[BURST-1] !== 1'b1) $display("FAIL t4_underflow_set got %b exp 1", obs_uf[BURST-1]); else passed++;
        total++; if (obs_fd[BURST] !== 8'h00) $display("FAIL t4_gap got %02h exp 00", obs_fd[BURST]); else passed++;
        total++; if (obs_fd[BURST+1] !== 8'hBC) $display("FAIL t4_new_header got %02h exp bc", obs_fd[BURST+1]); else passed++;
        total++; if (obs_uf[BURST+1] !== 1'b0) $display("FAIL t4_underflow_clear got %b exp 0", obs_uf[BURST+1]); else passed++;
        bif.start = 1'b0;
        wait_idle_b(BURST + 10, ok);
        total++; if (ok !== 1'b1) $display("FAIL t4_return_idle got %b exp 1", ok); else passed++;
    endtask

    task automatic test_upper_bits();
        clear_b();
        for (int i = 0; i < NF * FW; i++) push_b({4'hF, 32'($urandom)});
        build_exp(NF * FW);
        pulse_start_b();
        capture_b(BURST + 1);
        for (int i = 0; i < BURST; i++) begin
            total++; if (obs_fd[i] !== exp_q[i]) $display("FAIL t6_byte[%0d] got %02h exp %02h", i, obs_fd[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int p0, p_rst;
        bit ok;
        clear_b();
        for (int i = 0; i < NF * FW; i++) push_b({4'($urandom), 32'($urandom)});
        build_exp(NF * FW);
        p0 = pops_b;
        pulse_start_b();
        capture_b(11);
        for (int i = 0; i < 11; i++) begin
            total++; if (obs_fd[i] !== exp_q[i]) $display("FAIL t5_byte[%0d] got %02h exp %02h", i, obs_fd[i], exp_q[i]); else passed++;
        end
        rst = 1'b1;
        #1;
        total++; if (fd_b !== 8'h00) $display("FAIL t5_async_fd got %02h exp 00", fd_b); else passed++;
        total++; if ({bif.busy, bif.fifo_rd_en} !== 2'b00) $display("FAIL t5_async_flags got %b exp 00", {bif.busy, bif.fifo_rd_en}); else passed++;
        p_rst = pops_b;
        total++; if (p_rst - p0 !== 3) $display("FAIL t5_pops_before got %0d exp 3", p_rst - p0); else passed++;
        repeat (2) @(negedge clk);
        total++; if (pops_b !== p_rst) $display("FAIL t5_no_pops got %0d exp %0d", pops_b, p_rst); else passed++;
        rst = 1'b0;
        clear_b();
        for (int i = 0; i < FW; i++) push_b({4'($urandom), 32'($urandom)});
        build_exp(FW);
        pulse_start_b();
        capture_b(5);
        for (int i = 0; i < 5; i++) begin
            total++; if (obs_fd[i] !== exp_q[i]) $display("FAIL t5_restart[%0d] got %02h exp %02h", i, obs_fd[i], exp_q[i]); else passed++;
        end
        wait_idle_b(BURST + 10, ok);
        total++; if (ok !== 1'b1) $display("FAIL t5_return_idle got %b exp 1", ok); else passed++;
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_full_burst();
        test_underflow();
        test_restart_held();
        test_upper_bits();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
